// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard between IF and ID issue: decodes IR_IF, compares its sources
// against a shift register of in-flight destinations and raises hasHazard to stall fetch.
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int FORWARD = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR_IF,
  input  logic             in_valid,
  input  logic             flush,
  output logic             hasHazard,
  output logic             busy,
  output logic [CNT_W-1:0] hazard_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [4:0]       dest_q [DEPTH];
  logic [4:0]       dest_d [DEPTH];
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] opcode_s;
  logic [4:0] rs_s, rt_s, rd_s, dest_s;
  logic       use_rs_s, use_rt_s, load_s;
  logic       rs_used_s, rt_used_s, match_s, hazard_s, record_s;
  logic       ir_unused_s;

  assign opcode_s    = IR_IF[31:26];
  assign rs_s        = IR_IF[25:21];
  assign rt_s        = IR_IF[20:16];
  assign rd_s        = IR_IF[15:11];
  assign ir_unused_s = ^IR_IF[10:0];

  // Instruction decode: which sources are read, which register is written.
  always_comb begin
    use_rs_s = 1'b0;
    use_rt_s = 1'b0;
    load_s   = 1'b0;
    dest_s   = 5'd0;
    case (opcode_s)
      6'h00: begin
        use_rs_s = 1'b1;
        use_rt_s = 1'b1;
        dest_s   = rd_s;
      end
      6'h23: begin
        use_rs_s = 1'b1;
        load_s   = 1'b1;
        dest_s   = rt_s;
      end
      6'h2b, 6'h04, 6'h05: begin
        use_rs_s = 1'b1;
        use_rt_s = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        use_rs_s = 1'b1;
        dest_s   = rt_s;
      end
      default: begin
        use_rs_s = 1'b0;
        use_rt_s = 1'b0;
      end
    endcase
  end

  // $0 is hard-wired, so reading it can never depend on an in-flight writer.
  assign rs_used_s = use_rs_s & (rs_s != 5'd0);
  assign rt_used_s = use_rt_s & (rt_s != 5'd0);

  // Source match against the scoreboard; forwarding mode only stalls on load-use.
  always_comb begin
    match_s = 1'b0;
    if (FORWARD != 0) begin
      match_s = valid_q[0] & load_q[0] &
                ((rs_used_s & (dest_q[0] == rs_s)) | (rt_used_s & (dest_q[0] == rt_s)));
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        match_s = match_s | (valid_q[k] &
                  ((rs_used_s & (dest_q[k] == rs_s)) | (rt_used_s & (dest_q[k] == rt_s))));
      end
    end
  end

  assign hazard_s  = match_s & in_valid & ~flush;
  assign hasHazard = hazard_s;
  assign record_s  = in_valid & ~hazard_s & (dest_s != 5'd0);

  // Next scoreboard state: shift toward retirement, insert new writer or a bubble.
  always_comb begin
    valid_d = '0;
    load_d  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dest_d[k] = 5'd0;
    end
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d[0] = record_s;
      load_d[0]  = record_s & load_s;
      dest_d[0]  = dest_s;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
    end
    busy_d = |valid_d;
  end

  // Saturating count of stall cycles.
  always_comb begin
    if (hazard_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= 5'd0;
      end
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

  assign busy         = busy_q;
  assign hazard_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default stall mode, forwarding mode and a
// narrow saturating counter, each on its own instance sharing clock and reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir0, ir1, ir2;
  logic        v0, v1, v2, f0, f1, f2;
  logic        hz0, hz1, hz2, busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .IR_IF(ir0), .in_valid(v0), .flush(f0),
    .hasHazard(hz0), .busy(busy0), .hazard_count(cnt0));

  hazard_scoreboard #(.DEPTH(3), .FORWARD(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .IR_IF(ir1), .in_valid(v1), .flush(f1),
    .hasHazard(hz1), .busy(busy1), .hazard_count(cnt1));

  hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .IR_IF(ir2), .in_valid(v2), .flush(f2),
    .hasHazard(hz2), .busy(busy2), .hazard_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ir0 = 32'hffffffff; ir1 = 32'hffffffff; ir2 = 32'hffffffff;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    f0 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_cnt", {16'd0, cnt0}, 32'd0);
    chk("reset_hz", {31'd0, hz0}, 32'd0);

    // add $3 then sub $4,$3,$3 back to back: 3 stall cycles
    @(negedge clk); ir0 = 32'h00001820; v0 = 1'b1; #1;
    chk("raw_add_hz", {31'd0, hz0}, 32'd0);
    @(negedge clk); ir0 = 32'h00632022; #1;
    chk("raw_busy", {31'd0, busy0}, 32'd1);
    chk("raw_stall1", {31'd0, hz0}, 32'd1);
    @(negedge clk); #1;
    chk("raw_stall2", {31'd0, hz0}, 32'd1);
    @(negedge clk); #1;
    chk("raw_stall3", {31'd0, hz0}, 32'd1);
    @(negedge clk); #1;
    chk("raw_accept", {31'd0, hz0}, 32'd0);
    chk("raw_count", {16'd0, cnt0}, 32'd3);
    @(negedge clk); ir0 = 32'hffffffff; #1;
    chk("nop_hz", {31'd0, hz0}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("drain_busy", {31'd0, busy0}, 32'd0);

    // two intervening nops: 1 stall cycle
    @(negedge clk); ir0 = 32'h00001820; #1;
    chk("sep_add_hz", {31'd0, hz0}, 32'd0);
    @(negedge clk); ir0 = 32'hffffffff; #1;
    chk("sep_nop1", {31'd0, hz0}, 32'd0);
    @(negedge clk); #1;
    chk("sep_nop2", {31'd0, hz0}, 32'd0);
    @(negedge clk); ir0 = 32'h00632022; #1;
    chk("sep_stall", {31'd0, hz0}, 32'd1);
    @(negedge clk); #1;
    chk("sep_accept", {31'd0, hz0}, 32'd0);
    chk("sep_count", {16'd0, cnt0}, 32'd4);

    // lw $6 reading only $0 never stalls, even behind another writer of $6
    @(negedge clk); ir0 = 32'h8c060015; #1;
    chk("r0_a", {31'd0, hz0}, 32'd0);
    @(negedge clk); #1;
    chk("r0_b", {31'd0, hz0}, 32'd0);

    // three valid entries, stall in progress, then async reset mid-cycle
    @(negedge clk); ir0 = 32'h00001820; #1;
    @(negedge clk); ir0 = 32'h00632022; #1;
    chk("pre_rst_hz", {31'd0, hz0}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt0}, 32'd0);
    chk("mid_rst_hz", {31'd0, hz0}, 32'd0);
    @(negedge clk); rst = 1'b0; ir0 = 32'hffffffff;

    // flush in the cycle that would stall
    @(negedge clk); ir0 = 32'h00001820; #1;
    chk("fl_add_hz", {31'd0, hz0}, 32'd0);
    @(negedge clk); ir0 = 32'h00632022; f0 = 1'b1; #1;
    chk("flush_hz", {31'd0, hz0}, 32'd0);
    @(negedge clk); f0 = 1'b0; #1;
    chk("flush_busy", {31'd0, busy0}, 32'd0);
    chk("flush_nostall", {31'd0, hz0}, 32'd0);
    chk("flush_cnt", {16'd0, cnt0}, 32'd0);
    @(negedge clk); ir0 = 32'hffffffff; v0 = 1'b0;

    // forwarding mode: load-use stalls once, ALU dependency never
    ir1 = 32'h8c010014; v1 = 1'b1; #1;
    chk("fw_lw_hz", {31'd0, hz1}, 32'd0);
    @(negedge clk); ir1 = 32'h00232022; #1;
    chk("fw_stall", {31'd0, hz1}, 32'd1);
    @(negedge clk); #1;
    chk("fw_accept", {31'd0, hz1}, 32'd0);
    chk("fw_cnt", {16'd0, cnt1}, 32'd1);
    @(negedge clk); ir1 = 32'h00001820; #1;
    chk("fw_add_hz", {31'd0, hz1}, 32'd0);
    @(negedge clk); ir1 = 32'h00632022; #1;
    chk("fw_alu_hz", {31'd0, hz1}, 32'd0);
    @(negedge clk); ir1 = 32'hffffffff; #1;
    chk("fw_cnt2", {16'd0, cnt1}, 32'd1);

    // add $3,$3,$3 held: accept, 3 stalls, accept, ... until the 4-bit count saturates
    @(negedge clk); ir2 = 32'h00631820; v2 = 1'b1; #1;
    chk("sat_first_hz", {31'd0, hz2}, 32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    #1;
    chk("sat_mid_hz", {31'd0, hz2}, 32'd0);
    chk("sat_mid_cnt", {28'd0, cnt2}, 32'd6);
    for (int i = 0; i < 21; i++) @(negedge clk);
    #1;
    chk("sat_hz", {31'd0, hz2}, 32'd1);
    chk("sat_cnt", {28'd0, cnt2}, 32'hf);
    @(negedge clk); #1;
    chk("sat_hold", {28'd0, cnt2}, 32'hf);
    v2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
